// File: rtl/mips16_pkg.sv
// Shared definitions for the 16-bit MIPS pipeline: field widths, opcode and
// funct constants, ALU operation encodings and the ID-stage decode helper.
package mips16_pkg;

    localparam int INST_W = 16;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 9;
    localparam int REG_W  = 3;
    localparam int NREGS  = 8;

    localparam logic [3:0] OP_RTYPE = 4'h0;
    localparam logic [3:0] OP_ADDI  = 4'h1;
    localparam logic [3:0] OP_LW    = 4'h2;
    localparam logic [3:0] OP_SW    = 4'h3;
    localparam logic [3:0] OP_BEQ   = 4'h4;
    localparam logic [3:0] OP_BNE   = 4'h5;
    localparam logic [3:0] OP_J     = 4'h6;

    localparam logic [2:0] FN_ADD = 3'd0;
    localparam logic [2:0] FN_SUB = 3'd1;
    localparam logic [2:0] FN_AND = 3'd2;
    localparam logic [2:0] FN_OR  = 3'd3;
    localparam logic [2:0] FN_SLT = 3'd4;
    localparam logic [2:0] FN_SLL = 3'd5;
    localparam logic [2:0] FN_SRL = 3'd6;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4,
        ALU_SLL = 3'd5,
        ALU_SRL = 3'd6
    } alu_op_t;

    // Decoded view of one instruction. 'valid' means the instruction carries
    // work into EX; branches and jumps finish in ID and therefore leave it 0.
    typedef struct packed {
        logic             valid;
        alu_op_t          alu_op;
        logic             alu_src;
        logic             mem_read;
        logic             mem_write;
        logic             reg_write;
        logic [REG_W-1:0] dest;
        logic             illegal;
        logic             rt_is_src;
        logic             is_beq;
        logic             is_bne;
        logic             is_jump;
    } dec_t;

    function automatic logic [DATA_W-1:0] sext6_16(input logic [5:0] imm6);
        return {{(DATA_W-6){imm6[5]}}, imm6};
    endfunction

    function automatic logic [ADDR_W-1:0] sext6_9(input logic [5:0] imm6);
        return {{(ADDR_W-6){imm6[5]}}, imm6};
    endfunction

    function automatic dec_t decode(input logic [INST_W-1:0] inst);
        dec_t d;
        d        = '0;
        d.alu_op = ALU_ADD;
        case (inst[15:12])
            OP_RTYPE: begin
                d.rt_is_src = 1'b1;
                case (inst[2:0])
                    FN_ADD: d.alu_op = ALU_ADD;
                    FN_SUB: d.alu_op = ALU_SUB;
                    FN_AND: d.alu_op = ALU_AND;
                    FN_OR:  d.alu_op = ALU_OR;
                    FN_SLT: d.alu_op = ALU_SLT;
                    FN_SLL: d.alu_op = ALU_SLL;
                    FN_SRL: d.alu_op = ALU_SRL;
                    default: d.illegal = 1'b1;
                endcase
                if (!d.illegal) begin
                    d.valid     = 1'b1;
                    d.reg_write = 1'b1;
                    d.dest      = inst[5:3];
                end
            end
            OP_ADDI: begin
                d.valid     = 1'b1;
                d.alu_src   = 1'b1;
                d.reg_write = 1'b1;
                d.dest      = inst[8:6];
            end
            OP_LW: begin
                d.valid     = 1'b1;
                d.alu_src   = 1'b1;
                d.mem_read  = 1'b1;
                d.reg_write = 1'b1;
                d.dest      = inst[8:6];
            end
            OP_SW: begin
                d.valid     = 1'b1;
                d.alu_src   = 1'b1;
                d.mem_write = 1'b1;
                d.rt_is_src = 1'b1;
            end
            OP_BEQ: begin
                d.rt_is_src = 1'b1;
                d.is_beq    = 1'b1;
            end
            OP_BNE: begin
                d.rt_is_src = 1'b1;
                d.is_bne    = 1'b1;
            end
            OP_J: begin
                d.is_jump = 1'b1;
            end
            default: d.illegal = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/id_stage_if.sv
// Bus between the decode stage and its neighbours: fetch instruction input,
// write-back and EX hazard inputs, fetch redirect outputs and the ID/EX bundle.
// 'master' is the surrounding pipeline, 'slave' is id_stage.
interface id_stage_if;
    import mips16_pkg::*;

    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] next_address;
    logic              if_valid;
    logic              wb_wen;
    logic [REG_W-1:0]  wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              ex_mem_read;
    logic [REG_W-1:0]  ex_dest;

    logic              pc_src;
    logic [ADDR_W-1:0] branch_address;
    logic              pc_stall;

    logic              idex_valid;
    logic [DATA_W-1:0] idex_rs_data;
    logic [DATA_W-1:0] idex_rt_data;
    logic [DATA_W-1:0] idex_imm;
    logic [REG_W-1:0]  idex_dest;
    logic [2:0]        idex_alu_op;
    logic              idex_alu_src;
    logic              idex_mem_read;
    logic              idex_mem_write;
    logic              idex_reg_write;
    logic              illegal;

    modport master (
        output inst, next_address, if_valid,
        output wb_wen, wb_addr, wb_data,
        output ex_mem_read, ex_dest,
        input  pc_src, branch_address, pc_stall,
        input  idex_valid, idex_rs_data, idex_rt_data, idex_imm, idex_dest,
        input  idex_alu_op, idex_alu_src, idex_mem_read, idex_mem_write,
        input  idex_reg_write, illegal
    );

    modport slave (
        input  inst, next_address, if_valid,
        input  wb_wen, wb_addr, wb_data,
        input  ex_mem_read, ex_dest,
        output pc_src, branch_address, pc_stall,
        output idex_valid, idex_rs_data, idex_rt_data, idex_imm, idex_dest,
        output idex_alu_op, idex_alu_src, idex_mem_read, idex_mem_write,
        output idex_reg_write, illegal
    );

endinterface

// File: rtl/reg_file_8x16.sv
// 8x16 register file: two asynchronous read ports, one write port, r0 hardwired
// to zero. All registers clear on reset, so it is built from flops.
// Build option ID_WB_BYPASS_EN: a read of the register being written this
// cycle returns the incoming write data instead of the stored value.
module reg_file_8x16
    import mips16_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              wen,
    input  logic [REG_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [REG_W-1:0]  raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [REG_W-1:0]  raddr_b,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] rf_q [NREGS];

    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign rf_q[gi] = '0;
            end else begin : g_live
                logic [DATA_W-1:0] q_reg;

                // One storage register; writes to r0 never reach here.
                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) begin
                        q_reg <= '0;
                    end else if (wen && (waddr == REG_W'(gi))) begin
                        q_reg <= wdata;
                    end
                end

                assign rf_q[gi] = q_reg;
            end
        end
    endgenerate

`ifdef ID_WB_BYPASS_EN
    // Forward same-cycle write data; r0 is excluded so it still reads zero.
    assign rdata_a = (wen && (waddr == raddr_a) && (raddr_a != '0)) ? wdata : rf_q[raddr_a];
    assign rdata_b = (wen && (waddr == raddr_b) && (raddr_b != '0)) ? wdata : rf_q[raddr_b];
`else
    assign rdata_a = rf_q[raddr_a];
    assign rdata_b = rf_q[raddr_b];
`endif

endmodule

// File: rtl/id_stage.sv
// Instruction-decode stage of the 16-bit MIPS pipeline. Holds the IF/ID
// register, reads operands, decodes, resolves branches/jumps, detects
// load-use stalls and registers the result into ID/EX.
// Build option ID_WB_BYPASS_EN enables write-back bypass in the register file.
module id_stage
    import mips16_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    id_stage_if.slave bus
);

    logic [INST_W-1:0] ifid_inst_reg;
    logic [ADDR_W-1:0] ifid_na_reg;
    logic              ifid_valid_reg;

    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    dec_t              dec;

    logic              stall;
    logic              issue;
    logic              taken;
    logic [ADDR_W-1:0] br_target;

    logic              idex_valid_reg,     idex_valid_next;
    logic [DATA_W-1:0] idex_rs_data_reg,   idex_rs_data_next;
    logic [DATA_W-1:0] idex_rt_data_reg,   idex_rt_data_next;
    logic [DATA_W-1:0] idex_imm_reg,       idex_imm_next;
    logic [REG_W-1:0]  idex_dest_reg,      idex_dest_next;
    logic [2:0]        idex_alu_op_reg,    idex_alu_op_next;
    logic              idex_alu_src_reg,   idex_alu_src_next;
    logic              idex_mem_read_reg,  idex_mem_read_next;
    logic              idex_mem_write_reg, idex_mem_write_next;
    logic              idex_reg_write_reg, idex_reg_write_next;
    logic              illegal_reg,        illegal_next;

    assign rs  = ifid_inst_reg[11:9];
    assign rt  = ifid_inst_reg[8:6];
    assign dec = decode(ifid_inst_reg);

    reg_file_8x16 u_reg_file (
        .clk     (clk),
        .reset   (reset),
        .wen     (bus.wb_wen),
        .waddr   (bus.wb_addr),
        .wdata   (bus.wb_data),
        .raddr_a (rs),
        .rdata_a (rs_data),
        .raddr_b (rt),
        .rdata_b (rt_data)
    );

    // Load-use hazard: the load in EX produces a register this instruction
    // reads. rs is always treated as a source; rt only when the opcode uses it.
    assign stall = ifid_valid_reg && bus.ex_mem_read && (bus.ex_dest != '0) &&
                   ((bus.ex_dest == rs) || (dec.rt_is_src && (bus.ex_dest == rt)));

    // A stall takes priority; a pending branch resolves once the stall clears.
    assign issue = ifid_valid_reg && !stall;

    assign taken = issue && ((dec.is_beq && (rs_data == rt_data)) ||
                             (dec.is_bne && (rs_data != rt_data)) ||
                             dec.is_jump);

    // 9-bit add wraps naturally modulo 512.
    assign br_target = ifid_na_reg + sext6_9(ifid_inst_reg[5:0]);

    assign bus.pc_src         = taken;
    assign bus.pc_stall       = stall;
    assign bus.branch_address = taken ? (dec.is_jump ? ifid_inst_reg[8:0] : br_target) : '0;

    // IF/ID: hold while stalled, otherwise load; a redirect drops the
    // wrong-path instruction arriving at the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ifid_inst_reg  <= '0;
            ifid_na_reg    <= '0;
            ifid_valid_reg <= 1'b0;
        end else if (!stall) begin
            ifid_inst_reg  <= bus.inst;
            ifid_na_reg    <= bus.next_address;
            ifid_valid_reg <= bus.if_valid && !taken;
        end
    end

    // Next ID/EX contents: decoded fields when an EX-bound instruction issues,
    // an all-zero bubble otherwise (stall, empty slot, branch/jump, illegal).
    always_comb begin
        idex_valid_next     = 1'b0;
        idex_rs_data_next   = '0;
        idex_rt_data_next   = '0;
        idex_imm_next       = '0;
        idex_dest_next      = '0;
        idex_alu_op_next    = '0;
        idex_alu_src_next   = 1'b0;
        idex_mem_read_next  = 1'b0;
        idex_mem_write_next = 1'b0;
        idex_reg_write_next = 1'b0;
        illegal_next        = issue && dec.illegal;
        if (issue && dec.valid) begin
            idex_valid_next     = 1'b1;
            idex_rs_data_next   = rs_data;
            idex_rt_data_next   = rt_data;
            idex_imm_next       = sext6_16(ifid_inst_reg[5:0]);
            idex_dest_next      = dec.dest;
            idex_alu_op_next    = dec.alu_op;
            idex_alu_src_next   = dec.alu_src;
            idex_mem_read_next  = dec.mem_read;
            idex_mem_write_next = dec.mem_write;
            idex_reg_write_next = dec.reg_write;
        end
    end

    // ID/EX pipeline register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idex_valid_reg     <= 1'b0;
            idex_rs_data_reg   <= '0;
            idex_rt_data_reg   <= '0;
            idex_imm_reg       <= '0;
            idex_dest_reg      <= '0;
            idex_alu_op_reg    <= '0;
            idex_alu_src_reg   <= 1'b0;
            idex_mem_read_reg  <= 1'b0;
            idex_mem_write_reg <= 1'b0;
            idex_reg_write_reg <= 1'b0;
            illegal_reg        <= 1'b0;
        end else begin
            idex_valid_reg     <= idex_valid_next;
            idex_rs_data_reg   <= idex_rs_data_next;
            idex_rt_data_reg   <= idex_rt_data_next;
            idex_imm_reg       <= idex_imm_next;
            idex_dest_reg      <= idex_dest_next;
            idex_alu_op_reg    <= idex_alu_op_next;
            idex_alu_src_reg   <= idex_alu_src_next;
            idex_mem_read_reg  <= idex_mem_read_next;
            idex_mem_write_reg <= idex_mem_write_next;
            idex_reg_write_reg <= idex_reg_write_next;
            illegal_reg        <= illegal_next;
        end
    end

    assign bus.idex_valid     = idex_valid_reg;
    assign bus.idex_rs_data   = idex_rs_data_reg;
    assign bus.idex_rt_data   = idex_rt_data_reg;
    assign bus.idex_imm       = idex_imm_reg;
    assign bus.idex_dest      = idex_dest_reg;
    assign bus.idex_alu_op    = idex_alu_op_reg;
    assign bus.idex_alu_src   = idex_alu_src_reg;
    assign bus.idex_mem_read  = idex_mem_read_reg;
    assign bus.idex_mem_write = idex_mem_write_reg;
    assign bus.idex_reg_write = idex_reg_write_reg;
    assign bus.illegal        = illegal_reg;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed scenarios followed by random
// traffic, all compared against a behavioural model of the decode stage.
module tb_id_stage;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    id_stage_if bus();

    id_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks_total  = 0;
    int checks_passed = 0;

    // Model state: architectural registers, IF/ID slot, expected ID/EX.
    logic [15:0] m_regs [8];
    logic [15:0] m_inst;
    logic [8:0]  m_na;
    logic        m_v;

    logic        e_valid, e_src, e_mr, e_mw, e_rw, e_ill;
    logic [2:0]  e_alu, e_dest;
    logic [15:0] e_rs, e_rt, e_imm;

    logic        last_pc_src, last_pc_stall;
    logic [8:0]  last_ba;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks_total++;
        assert (obs === exp) checks_passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = '0;
        m_inst = '0; m_na = '0; m_v = 1'b0;
        e_valid = 0; e_src = 0; e_mr = 0; e_mw = 0; e_rw = 0; e_ill = 0;
        e_alu = '0; e_dest = '0; e_rs = '0; e_rt = '0; e_imm = '0;
    endtask

    task automatic set_in(input logic [15:0] inst, input logic [8:0] na, input logic ifv,
                          input logic wen, input logic [2:0] wa, input logic [15:0] wd,
                          input logic exmr, input logic [2:0] exd);
        bus.inst = inst; bus.next_address = na; bus.if_valid = ifv;
        bus.wb_wen = wen; bus.wb_addr = wa; bus.wb_data = wd;
        bus.ex_mem_read = exmr; bus.ex_dest = exd;
    endtask

    task automatic idle();
        set_in(16'h0000, 9'h000, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0);
    endtask

    function automatic logic [15:0] mread(input int r);
        if (r == 0) return 16'h0000;
`ifdef ID_WB_BYPASS_EN
        if (bus.wb_wen && int'(bus.wb_addr) == r) return bus.wb_data;
`endif
        return m_regs[r];
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_outs1"}, {bus.pc_src, bus.pc_stall, bus.branch_address, bus.idex_valid,
               bus.idex_alu_op, bus.idex_alu_src}, 16'h0000);
        check({tag, "_outs2"}, {bus.idex_mem_read, bus.idex_mem_write, bus.idex_reg_write,
               bus.illegal, bus.idex_dest}, 16'h0000);
        check({tag, "_rs"}, bus.idex_rs_data, 16'h0000);
        check({tag, "_rt"}, bus.idex_rt_data, 16'h0000);
        check({tag, "_imm"}, bus.idex_imm, 16'h0000);
    endtask

    // One clock: check fetch feedback against the model, advance the model
    // across the edge, then check the freshly registered ID/EX outputs.
    task automatic run_cycle();
        int op, rs, rt, rd, fn, simm, target;
        logic [15:0] rsv, rtv;
        bit rtsrc, stall, taken;
        logic n_valid, n_src, n_mr, n_mw, n_rw, n_ill;
        logic [2:0] n_alu, n_dest;
        #1;
        op = int'(m_inst[15:12]); rs = int'(m_inst[11:9]); rt = int'(m_inst[8:6]);
        rd = int'(m_inst[5:3]);   fn = int'(m_inst[2:0]);
        simm = int'(m_inst[5:0]);
        if (simm >= 32) simm = simm - 64;
        rsv = mread(rs); rtv = mread(rt);
        rtsrc = (op == 0) || (op == 3) || (op == 4) || (op == 5);
        stall = m_v && bus.ex_mem_read && (bus.ex_dest != 0) &&
                ((int'(bus.ex_dest) == rs) || (rtsrc && int'(bus.ex_dest) == rt));
        taken = m_v && !stall && ((op == 4 && rsv == rtv) || (op == 5 && rsv != rtv) || op == 6);
        target = (op == 6) ? int'(m_inst[8:0]) : (int'(m_na) + simm + 512) % 512;
        last_pc_src = bus.pc_src; last_pc_stall = bus.pc_stall; last_ba = bus.branch_address;
        check("pc_stall", 16'(bus.pc_stall), 16'(stall));
        check("pc_src", 16'(bus.pc_src), 16'(taken));
        check("branch_address", 16'(bus.branch_address), taken ? 16'(target) : 16'h0000);

        n_valid = 0; n_src = 0; n_mr = 0; n_mw = 0; n_rw = 0; n_ill = 0; n_alu = 0; n_dest = 0;
        if (m_v && !stall) begin
            case (op)
                0: begin n_valid = 1; n_rw = 1; n_alu = 3'(fn); n_dest = 3'(rd); end
                1: begin n_valid = 1; n_rw = 1; n_src = 1; n_dest = 3'(rt); end
                2: begin n_valid = 1; n_rw = 1; n_src = 1; n_mr = 1; n_dest = 3'(rt); end
                3: begin n_valid = 1; n_src = 1; n_mw = 1; end
                4, 5, 6: ;
                default: n_ill = 1;
            endcase
        end

        @(posedge clk);
        if (bus.wb_wen && bus.wb_addr != 0) m_regs[bus.wb_addr] = bus.wb_data;
        if (!stall) begin
            m_inst = bus.inst; m_na = bus.next_address; m_v = bus.if_valid && !taken;
        end
        e_valid = n_valid; e_src = n_src; e_mr = n_mr; e_mw = n_mw; e_rw = n_rw; e_ill = n_ill;
        e_alu = n_alu; e_dest = n_dest; e_rs = rsv; e_rt = rtv; e_imm = 16'(simm);
        #1;
        check("idex_ctrl",
              {7'd0, bus.idex_valid, bus.idex_alu_op, bus.idex_alu_src, bus.idex_mem_read,
               bus.idex_mem_write, bus.idex_reg_write, bus.illegal},
              {7'd0, e_valid, e_alu, e_src, e_mr, e_mw, e_rw, e_ill});
        if (e_valid) begin
            check("idex_rs_data", bus.idex_rs_data, e_rs);
            check("idex_rt_data", bus.idex_rt_data, e_rt);
        end
        if (e_rw)  check("idex_dest", 16'(bus.idex_dest), 16'(e_dest));
        if (e_src) check("idex_imm", bus.idex_imm, e_imm);
        $display("cycle t=%0t inst=%h v=%0b pc_src=%0b ba=%h stall=%0b idex_v=%0b rs=%h rt=%h",
                 $time, bus.inst, bus.if_valid, last_pc_src, last_ba, last_pc_stall,
                 bus.idex_valid, bus.idex_rs_data, bus.idex_rt_data);
    endtask

    initial begin
        logic [15:0] bypass_exp;
        logic [3:0]  rop;
        logic [15:0] rinst;

        reset = 1'b0;
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b1;

        // r1 = 5, r2 = 5 through write-back
        set_in(16'h0000, 9'h000, 0, 1, 3'd1, 16'd5, 0, 3'd0); run_cycle();
        set_in(16'h0000, 9'h000, 0, 1, 3'd2, 16'd5, 0, 3'd0); run_cycle();

        // add r3,r1,r2
        set_in(16'h0298, 9'h001, 1, 0, 3'd0, 16'h0, 0, 3'd0); run_cycle();
        idle(); run_cycle();
        check("add_rs", bus.idex_rs_data, 16'd5);
        check("add_rt", bus.idex_rt_data, 16'd5);
        check("add_dest", 16'(bus.idex_dest), 16'd3);
        check("add_alu_op", 16'(bus.idex_alu_op), 16'd0);
        check("add_reg_write", 16'(bus.idex_reg_write), 16'd1);

        // beq r1,r2,+3 at next_address 0x010; following fetch is flushed
        set_in(16'h4283, 9'h010, 1, 0, 3'd0, 16'h0, 0, 3'd0); run_cycle();
        set_in(16'h0298, 9'h011, 1, 0, 3'd0, 16'h0, 0, 3'd0); run_cycle();
        check("beq_pc_src", 16'(last_pc_src), 16'd1);
        check("beq_target", 16'(last_ba), 16'h0013);
        check("beq_bubble", 16'(bus.idex_valid), 16'd0);
        idle(); run_cycle();
        check("flush_bubble", 16'(bus.idex_valid), 16'd0);

        // bne r1,r3,-32 at next_address 0x005 wraps to 0x1E5
        set_in(16'h52E0, 9'h005, 1, 0, 3'd0, 16'h0, 0, 3'd0); run_cycle();
        idle(); run_cycle();
        check("bne_pc_src", 16'(last_pc_src), 16'd1);
        check("bne_wrap", 16'(last_ba), 16'h01E5);
        idle(); run_cycle();

        // load-use stall on sub r4,r1,r2
        set_in(16'h02A1, 9'h020, 1, 0, 3'd0, 16'h0, 0, 3'd0); run_cycle();
        set_in(16'h0298, 9'h021, 1, 0, 3'd0, 16'h0, 1, 3'd1); run_cycle();
        check("stall_on", 16'(last_pc_stall), 16'd1);
        check("stall_bubble", 16'(bus.idex_valid), 16'd0);
        set_in(16'h0298, 9'h021, 1, 0, 3'd0, 16'h0, 0, 3'd0); run_cycle();
        check("stall_off", 16'(last_pc_stall), 16'd0);
        check("sub_issue_op", 16'(bus.idex_alu_op), 16'd1);
        check("sub_issue_dest", 16'(bus.idex_dest), 16'd4);
        idle(); run_cycle();

        // same-cycle write-back of r6 while add r5,r6,r0 reads it
        set_in(16'h0000, 9'h000, 0, 1, 3'd6, 16'h1111, 0, 3'd0); run_cycle();
        set_in(16'h0C28, 9'h030, 1, 0, 3'd0, 16'h0, 0, 3'd0); run_cycle();
        set_in(16'h0000, 9'h000, 0, 1, 3'd6, 16'hBEEF, 0, 3'd0); run_cycle();
`ifdef ID_WB_BYPASS_EN
        bypass_exp = 16'hBEEF;
`else
        bypass_exp = 16'h1111;
`endif
        check("wb_same_cycle", bus.idex_rs_data, bypass_exp);

        // write to r0 is dropped; add r5,r0,r6
        set_in(16'h0000, 9'h000, 0, 1, 3'd0, 16'hDEAD, 0, 3'd0); run_cycle();
        set_in(16'h01A8, 9'h031, 1, 1, 3'd0, 16'hDEAD, 0, 3'd0); run_cycle();
        idle(); run_cycle();
        check("r0_reads_zero", bus.idex_rs_data, 16'h0000);
        check("r6_after_wb", bus.idex_rt_data, 16'hBEEF);

        // unknown opcode 0xF
        set_in(16'hF000, 9'h040, 1, 0, 3'd0, 16'h0, 0, 3'd0); run_cycle();
        idle(); run_cycle();
        check("illegal_flag", 16'(bus.illegal), 16'd1);
        check("illegal_bubble", 16'(bus.idex_valid), 16'd0);

        // random traffic with a mid-stream reset
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                reset = 1'b0;
                set_in(16'h4000, 9'h1FF, 1, 1, 3'd1, 16'hFFFF, 1, 3'd1);
                #1;
                check_all_zero("midreset");
                model_reset();
                @(posedge clk);
                #1;
                check_all_zero("midreset_hold");
                reset = 1'b1;
            end
            rop = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 6)) : 4'($urandom_range(0, 15));
            rinst = 16'($urandom);
            rinst[15:12] = rop;
            if (rop == 4'h0) rinst[2:0] = 3'($urandom_range(0, 6));
            set_in(rinst, 9'($urandom), ($urandom_range(0, 3) != 0),
                   1'($urandom), 3'($urandom), 16'($urandom),
                   ($urandom_range(0, 2) == 0), 3'($urandom));
            run_cycle();
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
